cic_decimator: RTL and testbench



---
 rtl/cic_pkg.sv | 26 ++
 rtl/cic_decimator_channel.sv | 64 ++++++
 rtl/cic_decimator.sv | 80 ++++++++
 tb/tb_cic_decimator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared sizing helpers and parameter bounds for the CIC decimator.
package cic_pkg;

  localparam int unsigned CIC_N_MIN   = 1;
  localparam int unsigned CIC_N_MAX   = 6;
  localparam int unsigned CIC_R_MIN   = 2;
  localparam int unsigned CIC_M_LIMIT = 1024;

  // Full-precision width: input width plus log2(R_max) bits of growth per stage.
  function automatic int unsigned cic_out_width(int unsigned width, int unsigned n,
                                                int unsigned m_max);
    return width + n * $clog2(m_max);
  endfunction

  function automatic int unsigned clamp_ratio(int unsigned ratio, int unsigned m_max);
    if (ratio < CIC_R_MIN) return CIC_R_MIN;
    if (ratio > m_max) return m_max;
    return ratio;
  endfunction

  function automatic bit cic_params_ok(int unsigned n, int unsigned m_max);
    return (n >= CIC_N_MIN) && (n <= CIC_N_MAX) &&
           (m_max >= CIC_R_MIN) && (m_max <= CIC_M_LIMIT);
  endfunction

endpackage

// File: rtl/cic_decimator_channel.sv
// One CIC datapath: N integrators, decimation latch, N comb stages and output register.
module cic_channel
  import cic_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned width = 11,
  parameter int unsigned OW    = 23
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 dec_event,
  input  logic [N:0]           tag,
  input  logic signed [width-1:0] x,
  output logic signed [OW-1:0] y
);

  logic signed [OW-1:0] integ_q [N];
  logic signed [OW-1:0] integ_d [N];
  // comb_q[0] is the decimated sample, comb_q[k] the output of comb stage k.
  logic signed [OW-1:0] comb_q [N+1];
  logic signed [OW-1:0] comb_d [N+1];
  logic signed [OW-1:0] dly_q  [N];
  logic signed [OW-1:0] dly_d  [N];
  logic signed [OW-1:0] y_q, y_d;

  always_comb begin
    integ_d = integ_q;
    comb_d  = comb_q;
    dly_d   = dly_q;
    y_d     = y_q;
    if (in_valid) begin
      integ_d[0] = integ_q[0] + {{(OW-width){x[width-1]}}, x};
      for (int unsigned k = 1; k < N; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
    if (dec_event) comb_d[0] = integ_q[N-1];
    for (int unsigned k = 1; k <= N; k++) begin
      if (tag[k-1]) begin
        comb_d[k]  = comb_q[k-1] - dly_q[k-1];
        dly_d[k-1] = comb_q[k-1];
      end
    end
    if (tag[N]) y_d = comb_q[N];
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      integ_q <= '{default: '0};
      comb_q  <= '{default: '0};
      dly_q   <= '{default: '0};
      y_q     <= '0;
    end else begin
      integ_q <= integ_d;
      comb_q  <= comb_d;
      dly_q   <= dly_d;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/cic_decimator.sv
// Multi-channel CIC decimator: shared counter, ratio register and valid tags; per-channel datapaths.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned M_MAX    = 16,
  parameter int unsigned width    = 11,
  parameter int unsigned CHANNELS = 2,
  localparam int unsigned OW      = cic_out_width(width, N, M_MAX),
  localparam int unsigned RW      = $clog2(M_MAX + 1)
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [CHANNELS*width-1:0] in,
  input  logic [RW-1:0]            ratio,
  output logic                     out_valid,
  output logic [CHANNELS*OW-1:0]   out,
  output logic [RW-1:0]            ratio_used
);

  localparam bit PARAMS_OK = cic_params_ok(N, M_MAX);

  logic [RW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] ratio_used_q, ratio_used_d;
  logic [RW-1:0] r_eff;
  logic [N:0]    tag_q, tag_d;
  logic          out_valid_q, out_valid_d;
  logic          dec_event;

  always_comb begin
    r_eff        = RW'(clamp_ratio(32'(ratio), M_MAX));
    dec_event    = in_valid && (cnt_q == ratio_used_q - RW'(1));
    cnt_d        = cnt_q;
    ratio_used_d = ratio_used_q;
    // tag[0] marks the latched sample, tag[k] comb stage k; out_valid follows tag[N].
    tag_d        = {tag_q[N-1:0], dec_event};
    out_valid_d  = tag_q[N];
    if (in_valid) cnt_d = dec_event ? '0 : cnt_q + RW'(1);
    if (dec_event) ratio_used_d = r_eff;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q        <= '0;
      ratio_used_q <= r_eff;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ratio_used_q <= ratio_used_d;
      tag_q        <= tag_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_ff @(posedge clk_in) begin
    assert (PARAMS_OK);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    cic_channel #(
      .N    (N),
      .width(width),
      .OW   (OW)
    ) u_ch (
      .clk_in   (clk_in),
      .reset    (reset),
      .in_valid (in_valid),
      .dec_event(dec_event),
      .tag      (tag_q),
      .x        (in[c*width +: width]),
      .y        (out[c*OW +: OW])
    );
  end

  assign out_valid  = out_valid_q;
  assign ratio_used = ratio_used_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed, table-driven bench for cic_decimator (N=3, M_MAX=16, width=11, 2 channels).
module tb_cic_decimator;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 11;
  localparam int unsigned CH = 2;
  localparam int unsigned OW = 23;
  localparam int unsigned RW = 5;

  logic              clk_in = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [CH*W-1:0]   in_s = '0;
  logic [RW-1:0]     ratio = 5'd10;
  logic              out_valid;
  logic [CH*OW-1:0]  out_s;
  logic [RW-1:0]     ratio_used;

  cic_decimator #(.N(N), .M_MAX(16), .width(W), .CHANNELS(CH)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in_s),
    .ratio     (ratio),
    .out_valid (out_valid),
    .out       (out_s),
    .ratio_used(ratio_used)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int o0; int o1; int ru; int cyc; } obs_t;
  obs_t obs[$];
  obs_t ref0[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic int sx(input logic [OW-1:0] v);
    logic signed [OW-1:0] t;
    t = v;
    return int'(t);
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in)
    if (out_valid) obs.push_back('{sx(out_s[OW-1:0]), sx(out_s[2*OW-1:OW]), int'(ratio_used), cyc});

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int a, input int b);
    in_s     = {W'(b), W'(a)};
    in_valid = 1'b1;
    @(posedge clk_in); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic do_reset(input int r);
    ratio    = RW'(r);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk_in); #1;
    reset    = 1'b0;
  endtask

  typedef struct {
    bit rst; int r; int reff; int x0; int x1; int nsamp; int gapmax;
    int skip; int e0; int e1; bit chk_first; int first0;
  } vec_t;
  vec_t tab[9];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected completion", n_vec);
    $fatal(1);
  end

  initial begin
    tab[0] = '{1, 10, 10,  1000,  1000,  80, 0, 3,  1000000,  1000000, 1,   84000};
    tab[1] = '{0, 10, 10, -1000, -1000,  80, 0, 3, -1000000, -1000000, 0,       0};
    tab[2] = '{0, 10, 10,     0,     0,  80, 0, 3,        0,        0, 0,       0};
    tab[3] = '{1, 16, 16, -1024, -1024, 128, 0, 3, -4194304, -4194304, 1, -465920};
    tab[4] = '{0, 16, 16,  1023,  1023, 128, 0, 3,  4190208,  4190208, 0,       0};
    tab[5] = '{1,  8,  8,   500,  -300,  64, 0, 3,   256000,  -153600, 1,   17500};
    tab[6] = '{1, 10, 10,  1000,  1000,  80, 3, 3,  1000000,  1000000, 1,   84000};
    tab[7] = '{1,  0,  2,  1000,  1000,  20, 0, 3,     8000,     8000, 1,       0};
    tab[8] = '{1, 20, 16,  1000,  1000, 128, 0, 3,  4096000,  4096000, 1,  455000};

    // Reset state
    reset = 1'b1; ratio = 5'd10;
    repeat (2) begin @(posedge clk_in); #1; end
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out0", sx(out_s[OW-1:0]), 0);
    check("rst_out1", sx(out_s[2*OW-1:OW]), 0);
    check("rst_ratio_used", int'(ratio_used), 10);
    reset = 1'b0;

    for (int p = 0; p < 9; p++) begin
      if (tab[p].rst) begin
        do_reset(tab[p].r);
        check($sformatf("p%0d_ratio_used_rst", p), int'(ratio_used), tab[p].reff);
      end else begin
        ratio = RW'(tab[p].r);
      end
      obs.delete();
      for (int s = 0; s < tab[p].nsamp; s++) begin
        send(tab[p].x0, tab[p].x1);
        if (tab[p].gapmax > 0) idle($urandom_range(tab[p].gapmax, 0));
      end
      idle(N + 5);
      check($sformatf("p%0d_n_out", p), obs.size(), tab[p].nsamp / tab[p].reff);
      if (tab[p].chk_first && obs.size() > 0)
        check($sformatf("p%0d_first", p), obs[0].o0, tab[p].first0);
      for (int i = tab[p].skip; i < obs.size(); i++) begin
        check($sformatf("p%0d_o%0d_ch0", p, i), obs[i].o0, tab[p].e0);
        check($sformatf("p%0d_o%0d_ch1", p, i), obs[i].o1, tab[p].e1);
        check($sformatf("p%0d_o%0d_ru", p, i), obs[i].ru, tab[p].reff);
      end
      if (p == 0) begin
        ref0 = obs;
        for (int i = 1; i < obs.size(); i++)
          check($sformatf("p0_spacing%0d", i), obs[i].cyc - obs[i-1].cyc, 10);
      end
      if (p == 6) begin
        for (int i = 0; i < obs.size() && i < ref0.size(); i++) begin
          check($sformatf("gap_vs_ref_o%0d_ch0", i), obs[i].o0, ref0[i].o0);
          check($sformatf("gap_vs_ref_o%0d_ch1", i), obs[i].o1, ref0[i].o1);
        end
      end
    end

    // Latency: out_valid exactly N+1 cycles after the decimation edge
    do_reset(4);
    obs.delete();
    repeat (4) send(1000, 1000);
    in_valid = 1'b0;
    check("lat_e0", int'(out_valid), 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_in); #1;
      check($sformatf("lat_e%0d", k), int'(out_valid), 0);
    end
    @(posedge clk_in); #1;
    check("lat_e4_valid", int'(out_valid), 1);
    check("lat_e4_out", sx(out_s[OW-1:0]), 1000);
    @(posedge clk_in); #1;
    check("lat_e5_valid", int'(out_valid), 0);
    check("lat_e5_hold", sx(out_s[OW-1:0]), 1000);

    // Reset during comb flush
    repeat (4) send(1000, 1000);
    in_valid = 1'b0;
    @(posedge clk_in); #1;
    obs.delete();
    reset = 1'b1;
    @(posedge clk_in); #1;
    reset = 1'b0;
    check("mid_rst_out0", sx(out_s[OW-1:0]), 0);
    check("mid_rst_out1", sx(out_s[2*OW-1:OW]), 0);
    idle(8);
    check("mid_rst_no_pulse", obs.size(), 0);
    check("mid_rst_out_after", sx(out_s[OW-1:0]), 0);
    repeat (16) send(1000, 1000);
    idle(N + 5);
    check("post_rst_n_out", obs.size(), 4);
    if (obs.size() == 4) begin
      check("post_rst_first", obs[0].o0, 1000);
      check("post_rst_4th_ch0", obs[3].o0, 64000);
      check("post_rst_4th_ch1", obs[3].o1, 64000);
    end

    // Ratio change 10 -> 4 at frame count 5
    do_reset(10);
    obs.delete();
    repeat (45) send(1000, 1000);
    ratio = 5'd4;
    repeat (4) send(1000, 1000);
    check("rchg_ru_before", int'(ratio_used), 10);
    send(1000, 1000);
    check("rchg_ru_after", int'(ratio_used), 4);
    repeat (40) send(1000, 1000);
    idle(N + 5);
    check("rchg_n_out", obs.size(), 15);
    if (obs.size() == 15) begin
      check("rchg_o4_val", obs[4].o0, 1000000);
      check("rchg_sp4", obs[4].cyc - obs[3].cyc, 10);
      check("rchg_sp5", obs[5].cyc - obs[4].cyc, 4);
      check("rchg_sp6", obs[6].cyc - obs[5].cyc, 4);
      for (int i = 8; i < 15; i++)
        check($sformatf("rchg_o%0d", i), obs[i].o0, 64000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
